// File: rtl/adc_scan_pkg.sv
// Shared types and constants for the ADC scan controller: FSM states,
// config-word bit positions and channel-selection helpers.
package adc_scan_pkg;

  typedef enum logic [2:0] {IDLE, CONV_HI, CONV_WAIT, SHIFT, GAP} scan_state_t;

  localparam int RES_W   = 12;
  localparam int SD_BIT  = 11;
  localparam int OS_BIT  = 10;
  localparam int S1_BIT  = 9;
  localparam int S0_BIT  = 8;
  localparam int UNI_BIT = 7;
  localparam int SLP_BIT = 6;

  function automatic logic [RES_W-1:0] cfg_word(input logic [2:0] ch, input logic uni);
    logic [RES_W-1:0] w;
    w          = '0;
    w[SD_BIT]  = 1'b1;
    w[OS_BIT]  = ch[0];
    w[S1_BIT]  = ch[2];
    w[S0_BIT]  = ch[1];
    w[UNI_BIT] = uni;
    w[SLP_BIT] = 1'b0;
    return w;
  endfunction

  // First set mask bit at or above base, wrapping past channel 7.
  function automatic logic [2:0] pick_ch(input logic [2:0] base, input logic [7:0] mask);
    logic [2:0] idx;
    logic [2:0] sel;
    logic       found;
    sel   = base;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = base + 3'(i);
      if (!found && mask[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/adc_spi_shift.sv
// SPI engine: SCK divider, 12-bit config/result shifters and bit counter.
// start loads the config word; done is high in the last cycle of the transfer.
module adc_spi_shift
  import adc_scan_pkg::*;
#(
  parameter int SCK_HALF = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [RES_W-1:0] cfg,
  input  logic             sdo,
  output logic             sck,
  output logic             sdi,
  output logic             done,
  output logic [RES_W-1:0] rx
);

  localparam int HALF_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(SCK_HALF - 1);
  localparam logic [3:0]        BIT_LAST  = 4'(RES_W - 1);

  logic              active;
  logic [HALF_W-1:0] half_cnt;
  logic [3:0]        bit_cnt;
  logic [RES_W-1:0]  tx_sh;
  logic              half_end;

  assign half_end = active && (half_cnt == HALF_LAST);
  assign done     = half_end && sck && (bit_cnt == BIT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active   <= 1'b0;
      sck      <= 1'b0;
      sdi      <= 1'b0;
      half_cnt <= '0;
      bit_cnt  <= '0;
    end else if (start) begin
      active   <= 1'b1;
      sck      <= 1'b0;
      sdi      <= cfg[RES_W-1];
      half_cnt <= '0;
      bit_cnt  <= '0;
    end else if (active) begin
      if (half_end) begin
        half_cnt <= '0;
        if (!sck) begin
          sck <= 1'b1;
        end else begin
          // Falling edge: present the next config bit, or finish after bit 12.
          sck <= 1'b0;
          if (bit_cnt == BIT_LAST) begin
            active <= 1'b0;
            sdi    <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            sdi     <= tx_sh[RES_W-1];
          end
        end
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start)
      tx_sh <= {cfg[RES_W-2:0], 1'b0};
    else if (half_end && sck)
      tx_sh <= {tx_sh[RES_W-2:0], 1'b0};
    if (half_end && !sck)
      rx <= {rx[RES_W-2:0], sdo};
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Round-robin scan controller for an 8-channel SPI ADC. Each frame programs
// one channel and reads back the conversion of the channel programmed before.
module adc_scan_ctrl
  import adc_scan_pkg::*;
#(
  parameter int CONV_CYCLES = 80,
  parameter int SCK_HALF    = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [7:0]       ch_mask,
  input  logic             uni,
  output logic             adc_convst,
  output logic             adc_sck,
  output logic             adc_sdi,
  input  logic             adc_sdo,
  output logic             busy,
  output logic             result_valid,
  output logic [2:0]       result_ch,
  output logic [RES_W-1:0] result_data
);

  localparam int CNT_W = $clog2(CONV_CYCLES + 1);
  localparam logic [CNT_W-1:0] HI_LAST   = CNT_W'(1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(CONV_CYCLES - 1);

  scan_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       mask_q;
  logic             uni_q;
  logic [2:0]       ch_cur;
  logic [2:0]       prev_ch;
  logic [2:0]       ch_adv;
  logic             prev_ok;
  logic             scan_req;
  logic             spi_start;
  logic             spi_done;
  logic [RES_W-1:0] spi_rx;
  logic [RES_W-1:0] cfg;

  assign scan_req  = enable && (ch_mask != 8'h00);
  assign spi_start = (state == CONV_WAIT) && (cnt == WAIT_LAST);
  assign cfg       = cfg_word(ch_cur, uni_q);
  assign ch_adv    = pick_ch(ch_cur + 3'd1, mask_q);

  adc_spi_shift #(.SCK_HALF(SCK_HALF)) u_spi (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (spi_start),
    .cfg     (cfg),
    .sdo     (adc_sdo),
    .sck     (adc_sck),
    .sdi     (adc_sdi),
    .done    (spi_done),
    .rx      (spi_rx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      adc_convst   <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_ch    <= '0;
      result_data  <= '0;
      prev_ok      <= 1'b0;
      prev_ch      <= '0;
      ch_cur       <= '0;
      mask_q       <= '0;
      uni_q        <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (scan_req) begin
            state      <= CONV_HI;
            adc_convst <= 1'b1;
            busy       <= 1'b1;
            cnt        <= '0;
            mask_q     <= ch_mask;
            uni_q      <= uni;
            ch_cur     <= pick_ch(ch_cur, ch_mask);
          end
        end
        CONV_HI: begin
          if (cnt == HI_LAST) begin
            state      <= CONV_WAIT;
            adc_convst <= 1'b0;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CONV_WAIT: begin
          if (spi_start) begin
            state <= SHIFT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          // Bits shifted in belong to the channel programmed last frame.
          if (spi_done) begin
            state        <= GAP;
            result_valid <= prev_ok;
            if (prev_ok) begin
              result_ch   <= prev_ch;
              result_data <= spi_rx;
            end
          end
        end
        GAP: begin
          prev_ch <= ch_cur;
          if (scan_req) begin
            state      <= CONV_HI;
            adc_convst <= 1'b1;
            cnt        <= '0;
            prev_ok    <= 1'b1;
            mask_q     <= ch_mask;
            uni_q      <= uni;
            ch_cur     <= pick_ch(ch_adv, ch_mask);
          end else begin
            state   <= IDLE;
            busy    <= 1'b0;
            prev_ok <= 1'b0;
            ch_cur  <= ch_adv;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
